// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with an N-key rollover table.
// Raw pad pins are synchronised and glitch-filtered. 11-bit device frames are
// deframed and checked, then E0/F0 prefixes are decoded into make/break events
// that fill or free NUM_KEYS key slots.
module ps2_key_tracker #(
    parameter int NUM_KEYS    = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  ps2_clk,
    input  logic                  ps2_dat,
    output logic [7:0]            scandata,
    output logic                  scan_valid,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [NUM_KEYS-1:0]   key_on,
    output logic [NUM_KEYS*9-1:0] key_code
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0] EMPTY_CODE = 9'h0F0;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            state, next_state;
    logic              clk_s0, clk_s1, dat_s0, dat_s1;
    logic              clk_filt;
    logic [FLT_W-1:0]  flt_cnt;
    logic              flt_done, fall_evt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              par_bit;
    logic [WD_W-1:0]   wd_cnt;
    logic              shift_en, par_en, byte_ok, byte_bad, timeout;
    logic              ext_flag, brk_flag, is_status;
    logic [8:0]        event_code;
    logic [8:0]        slot_code [NUM_KEYS];
    logic [NUM_KEYS-1:0] hit_vec, free_vec, free_oh;

    // Two-flop synchronisers; the bus idles high.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            clk_s0 <= 1'b1;
            clk_s1 <= 1'b1;
            dat_s0 <= 1'b1;
            dat_s1 <= 1'b1;
        end else begin
            clk_s0 <= ps2_clk;
            clk_s1 <= clk_s0;
            dat_s0 <= ps2_dat;
            dat_s1 <= dat_s0;
        end
    end

    // The filtered clock follows only after FILTER_LEN consecutive differing samples.
    assign flt_done = (clk_s1 != clk_filt) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign fall_evt = flt_done && clk_filt;

    // Filter counter and filtered clock level.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_s1 == clk_filt) begin
            flt_cnt  <= '0;
        end else if (flt_done) begin
            clk_filt <= clk_s1;
            flt_cnt  <= '0;
        end else begin
            flt_cnt  <= flt_cnt + FLT_W'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Frame FSM next state and per-fall actions; the watchdog only aborts mid-frame.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        timeout    = (state != S_IDLE) && !fall_evt && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
        case (state)
            S_IDLE: begin
                if (fall_evt && !dat_s1) next_state = S_DATA;
            end
            S_DATA: begin
                if (fall_evt) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) next_state = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall_evt) begin
                    par_en     = 1'b1;
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_evt) begin
                    if (dat_s1 && (^{par_bit, shift_reg})) byte_ok  = 1'b1;
                    else                                   byte_bad = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (timeout) next_state = S_IDLE;
    end

    // Bit counter and watchdog; both idle at zero outside a frame.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            if (state == S_IDLE)  bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;
            if (state == S_IDLE || fall_evt) wd_cnt <= '0;
            else                             wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Payload shift register (LSB first) and parity capture; pure data, no reset.
    always_ff @(posedge sys_clk) begin
        if (shift_en) shift_reg <= {dat_s1, shift_reg[7:1]};
        if (par_en)   par_bit   <= dat_s1;
    end

    // Received byte and status pulses, one cycle after the stop-bit fall.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            scandata   <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= byte_ok;
            frame_err  <= byte_bad | timeout;
            if (byte_ok) scandata <= shift_reg;
        end
    end

    // Classify the received byte and locate matching / lowest free slots.
    always_comb begin
        event_code = {ext_flag, scandata};
        case (scandata)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_status = 1'b1;
            default:                                                is_status = 1'b0;
        endcase
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit_vec[i] = key_on[i] && (slot_code[i] == event_code);
        end
        free_vec = ~key_on;
        free_oh  = free_vec & (~free_vec + NUM_KEYS'(1));
    end

    // Decoder: prefix flags and key table; clear overrides any coincident event.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            overflow <= 1'b0;
            key_on   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) slot_code[i] <= EMPTY_CODE;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                key_on   <= '0;
                for (int i = 0; i < NUM_KEYS; i++) slot_code[i] <= EMPTY_CODE;
            end else if (scan_valid) begin
                if (scandata == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (scandata == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (!is_status) begin
                        if (brk_flag) begin
                            for (int i = 0; i < NUM_KEYS; i++) begin
                                if (hit_vec[i]) begin
                                    key_on[i]    <= 1'b0;
                                    slot_code[i] <= EMPTY_CODE;
                                end
                            end
                        end else if (hit_vec == '0) begin
                            if (free_oh == '0) overflow <= 1'b1;
                            for (int i = 0; i < NUM_KEYS; i++) begin
                                if (free_oh[i]) begin
                                    key_on[i]    <= 1'b1;
                                    slot_code[i] <= event_code;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Flatten the slot table onto the output bus.
    always_comb begin
        key_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) key_code[9*i +: 9] = slot_code[i];
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed frames plus random traffic
// compared against a byte-level key-table model.
module tb_ps2_key_tracker;

    localparam int NK   = 4;
    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic            sys_clk = 1'b0;
    logic            reset   = 1'b0;
    logic            clear   = 1'b0;
    logic            ps2_clk = 1'b1;
    logic            ps2_dat = 1'b1;
    logic [7:0]      scandata;
    logic            scan_valid, frame_err, overflow;
    logic [NK-1:0]   key_on;
    logic [NK*9-1:0] key_code;

    ps2_key_tracker #(.NUM_KEYS(NK), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .reset(reset), .clear(clear),
        .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .scandata(scandata), .scan_valid(scan_valid), .frame_err(frame_err),
        .overflow(overflow), .key_on(key_on), .key_code(key_code)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters observed on the falling edge.
    int sv_seen = 0, fe_seen = 0, ov_seen = 0;
    always @(negedge sys_clk) begin
        if (scan_valid === 1'b1) sv_seen++;
        if (frame_err  === 1'b1) fe_seen++;
        if (overflow   === 1'b1) ov_seen++;
    end

    // Reference model state.
    logic [8:0] m_code [NK];
    bit         m_on   [NK];
    bit         m_ext, m_brk;
    logic [7:0] m_scan;
    int         exp_sv = 0, exp_fe = 0, exp_ov = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_code[i] = 9'h0F0;
            m_on[i]   = 1'b0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [8:0] k;
        int found, free;
        exp_sv++;
        m_scan = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            k = {m_ext, b};
            found = -1;
            for (int i = 0; i < NK; i++) if (m_on[i] && m_code[i] == k) found = i;
            if (!m_brk) begin
                if (found < 0) begin
                    free = -1;
                    for (int i = NK - 1; i >= 0; i--) if (!m_on[i]) free = i;
                    if (free < 0) exp_ov++;
                    else begin
                        m_on[free]   = 1'b1;
                        m_code[free] = k;
                    end
                end
            end else if (found >= 0) begin
                m_on[found]   = 1'b0;
                m_code[found] = 9'h0F0;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [NK-1:0]   e_on;
        logic [NK*9-1:0] e_code;
        for (int i = 0; i < NK; i++) begin
            e_on[i]          = m_on[i];
            e_code[9*i +: 9] = m_code[i];
        end
        check_val({tag, "_scan_valid_cnt"}, sv_seen, exp_sv);
        check_val({tag, "_frame_err_cnt"}, fe_seen, exp_fe);
        check_val({tag, "_overflow_cnt"}, ov_seen, exp_ov);
        check_val({tag, "_scandata"}, scandata, m_scan);
        check_val({tag, "_key_on"}, key_on, e_on);
        check_val({tag, "_key_code"}, key_code, e_code);
    endtask

    // One device bit: data changes while the clock is high, then the clock falls.
    task automatic ps2_bit(input logic b, input bit glitch);
        int g;
        ps2_dat = b;
        if (glitch) begin
            wait_clk(HALF / 2);
            g = $urandom_range(1, 3);
            ps2_clk = 1'b0;
            wait_clk(g);
            ps2_clk = 1'b1;
            wait_clk(HALF / 2 - g);
        end else begin
            wait_clk(HALF);
        end
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit apply);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit(par, glitch);
        ps2_bit(~bad_stop, glitch);
        ps2_dat = 1'b1;
        wait_clk(HALF);
        if (apply) begin
            if (bad_par || bad_stop) exp_fe++;
            else                     model_byte(b);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pool [12];
        logic [7:0] b;
        bit bad;
        bit seen;
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75, 8'h15, 8'hE0,
                 8'hF0, 8'hF0, 8'hAA, 8'h00};
        model_reset();
        m_scan = 8'h00;

        // Reset state
        wait_clk(5);
        check_val("rst_scandata", scandata, 8'h00);
        check_val("rst_scan_valid", scan_valid, 1'b0);
        check_val("rst_frame_err", frame_err, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_key_on", key_on, '0);
        check_val("rst_key_code", key_code, {NK{9'h0F0}});
        reset = 1'b1;
        wait_clk(5);

        // Single make, then fill the table and overflow
        send_frame(8'h1C, 0, 0, 0, 1);
        check_state("make_1c");
        check_val("make_1c_slot0", key_code[8:0], 9'h01C);
        foreach (pool[i]) if (i >= 1 && i <= 4) send_frame(pool[i], 0, 0, 0, 1);
        check_state("fill_overflow");
        check_val("fill_key_on", key_on, 4'b1111);
        check_val("overflow_once", ov_seen, 1);

        // Break frees slot1, next make reuses it
        send_frame(8'hF0, 0, 0, 0, 1);
        send_frame(8'h1B, 0, 0, 0, 1);
        check_state("break_1b");
        send_frame(8'h34, 0, 0, 0, 1);
        check_state("refill_34");
        check_val("refill_slot1", key_code[17:9], 9'h034);

        // Clear empties the table
        clear = 1'b1;
        wait_clk(1);
        clear = 1'b0;
        model_reset();
        wait_clk(2);
        check_state("clear");

        // Extended make/break and flag clearing
        send_frame(8'hE0, 0, 0, 0, 1);
        send_frame(8'h75, 0, 0, 0, 1);
        check_state("ext_make");
        check_val("ext_slot0", key_code[8:0], 9'h175);
        send_frame(8'hE0, 0, 0, 0, 1);
        send_frame(8'hF0, 0, 0, 0, 1);
        send_frame(8'h75, 0, 0, 0, 1);
        check_state("ext_break");
        send_frame(8'h75, 0, 0, 0, 1);
        check_state("flags_cleared");
        check_val("plain_75_slot0", key_code[8:0], 9'h075);

        // Parity and stop errors
        send_frame(8'h1C, 1, 0, 0, 1);
        check_state("bad_parity");
        send_frame(8'h1C, 0, 1, 0, 1);
        check_state("bad_stop");

        // Watchdog abort after 4 data bits
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 0);
        ps2_dat = 1'b1;
        wait_clk(TO - 200);
        check_val("timeout_not_early", fe_seen, exp_fe);
        wait_clk(400);
        exp_fe++;
        check_val("timeout_err", fe_seen, exp_fe);
        send_frame(8'h15, 0, 0, 1, 1);
        check_state("after_timeout_glitch");

        // Reset mid-frame
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        reset = 1'b0;
        wait_clk(3);
        model_reset();
        m_scan = 8'h00;
        check_state("mid_reset");
        reset = 1'b1;
        wait_clk(5);
        send_frame(8'h1C, 0, 0, 0, 1);
        check_state("after_mid_reset");

        // Clear coinciding with a decoder event: clear wins
        seen = 1'b0;
        fork
            send_frame(8'h2B, 0, 0, 0, 0);
            begin
                for (int c = 0; c < 2000 && !seen; c++) begin
                    @(negedge sys_clk);
                    if (scan_valid === 1'b1) begin
                        seen  = 1'b1;
                        clear = 1'b1;
                        @(posedge sys_clk);
                        #1;
                        clear = 1'b0;
                    end
                end
            end
        join
        check_val("clear_coincide_seen", seen, 1'b1);
        exp_sv++;
        m_scan = 8'h2B;
        model_reset();
        check_state("clear_coincide");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            b   = pool[$urandom_range(0, 11)];
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad && $urandom_range(0, 1) == 0, bad && $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, 1);
            check_state($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
